sc_mult_scheduler: RTL and testbench

SC_MULT_SCHEDULER -- requirements
Module: sc_mult_scheduler

---
 rtl/sc_mult_scheduler_if.sv | 29 ++
 rtl/sc_mult_scheduler.sv | 157 +++++++++++++++
 tb/tb_sc_mult_scheduler.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_mult_scheduler_if.sv
// Purpose : operand/result handshake bundle for the stochastic bipolar multiplier scheduler.
// Latency : n/a (wires only).
// Backpressure: in_ready gates operand acceptance; out_ready holds a finished result in place.
// Ports (slave = scheduler side):
//   in_valid/in_ready/x_code/y_code  operand request channel
//   out_valid/out_ready/z_count      result channel
//   busy/stream_valid/z_bit          status and product-stream observation
interface sc_mult_scheduler_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x_code;
    logic [7:0] y_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] z_count;
    logic       busy;
    logic       stream_valid;
    logic       z_bit;

    modport slave (
        input  in_valid, x_code, y_code, out_ready,
        output in_ready, out_valid, z_count, busy, stream_valid, z_bit
    );

    modport master (
        output in_valid, x_code, y_code, out_ready,
        input  in_ready, out_valid, z_count, busy, stream_valid, z_bit
    );
endinterface

// File: rtl/sc_mult_scheduler.sv
// Purpose : runs one 255-bit bipolar stochastic multiply per accepted operand pair and counts product ones.
// Latency : operands accepted at edge T -> out_valid high in the cycle after edge T+255.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no new accept on the handoff edge.
// Ports:
//   clk, rst  single clock, synchronous active-high reset
//   bus       sc_mult_scheduler_if.slave (operands in, ones-count out, status/stream observation)

// Bipolar stochastic multiplier: product bit is XNOR of the two input stream bits.
module sc_multiplier_bi (
    input  logic x,
    input  logic y,
    output logic z
);
    assign z = ~(x ^ y);
endmodule

module sc_mult_scheduler (
    input  logic                  clk,
    input  logic                  rst,
    sc_mult_scheduler_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] SEED_A     = 8'h01;
    localparam logic [7:0] SEED_B     = 8'hA5;
    // Counter value during the 255th RUN cycle (counter starts at 0).
    localparam logic [7:0] LAST_CYCLE = 8'd254;

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_lfsr_a;
    logic [7:0] r_lfsr_b;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [7:0] r_cycle_cnt;
    logic [7:0] r_ones_cnt;
    logic [7:0] r_z_count;

    logic       w_fb_a;
    logic       w_fb_b;
    logic       w_x_bit;
    logic       w_y_bit;
    logic       w_z;
    logic       w_accept;
    logic       w_last;
    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_busy;
    logic       w_stream_valid;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1; maximal length, so a nonzero seed
    // walks all 255 nonzero states and never reaches 0.
    assign w_fb_a = r_lfsr_a[7] ^ r_lfsr_a[5] ^ r_lfsr_a[4] ^ r_lfsr_a[3];
    assign w_fb_b = r_lfsr_b[7] ^ r_lfsr_b[5] ^ r_lfsr_b[4] ^ r_lfsr_b[3];

    // LFSR range is 1..255, so code 0 yields a constant-0 stream and code 255 a constant-1 stream.
    assign w_x_bit = (r_lfsr_a <= r_x);
    assign w_y_bit = (r_lfsr_b <= r_y);

    sc_multiplier_bi u_mult (
        .x (w_x_bit),
        .y (w_y_bit),
        .z (w_z)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_next_state   = r_state;
        w_in_ready     = 1'b0;
        w_out_valid    = 1'b0;
        w_busy         = 1'b1;
        w_stream_valid = 1'b0;
        w_accept       = 1'b0;
        w_last         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_stream_valid = 1'b1;
                if (r_cycle_cnt == LAST_CYCLE) begin
                    w_last       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                // Returning to IDLE here; in_ready is low this cycle so the
                // handoff edge can never also accept a new pair.
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, stream generators, counters, result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr_a    <= SEED_A;
            r_lfsr_b    <= SEED_B;
            r_x         <= 8'd0;
            r_y         <= 8'd0;
            r_cycle_cnt <= 8'd0;
            r_ones_cnt  <= 8'd0;
            r_z_count   <= 8'd0;
        end else if (w_accept) begin
            r_x         <= bus.x_code;
            r_y         <= bus.y_code;
            r_lfsr_a    <= SEED_A;
            r_lfsr_b    <= SEED_B;
            r_cycle_cnt <= 8'd0;
            r_ones_cnt  <= 8'd0;
            // Result reads 0 for the whole run until the new count lands.
            r_z_count   <= 8'd0;
        end else if (w_stream_valid) begin
            r_lfsr_a    <= {r_lfsr_a[6:0], w_fb_a};
            r_lfsr_b    <= {r_lfsr_b[6:0], w_fb_b};
            r_cycle_cnt <= r_cycle_cnt + 8'd1;
            r_ones_cnt  <= r_ones_cnt + {7'd0, w_z};
            // At most 255 ones in 255 cycles, so 8 bits cannot wrap.
            if (w_last) begin
                r_z_count <= r_ones_cnt + {7'd0, w_z};
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.busy         = w_busy;
    assign bus.stream_valid = w_stream_valid;
    assign bus.z_bit        = w_stream_valid & w_z;
    assign bus.z_count      = r_z_count;
endmodule

// File: tb/tb_sc_mult_scheduler.sv
// Purpose : self-checking bench for sc_mult_scheduler (table vectors, random pairs, corner sequences).
// Latency : expects out_valid 256 cycles after the acceptance edge.
// Backpressure: exercises held out_ready, handoff edge, reset aborts and back-to-back streaming.
module tb_sc_mult_scheduler;
    logic clk;
    logic rst;

    sc_mult_scheduler_if bus();

    sc_mult_scheduler u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: the two generator sequences over one full period.
    logic [7:0] seq_a [255];
    logic [7:0] seq_b [255];

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        int         exp_z;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic [7:0] masked;
        masked = v & 8'hB8;
        return {v[6:0], ^masked};
    endfunction

    // Ones count of XNOR(a<=x, b<=y) over the whole period.
    function automatic int model(input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        for (int k = 0; k < 255; k++) begin
            if ((seq_a[k] <= x) == (seq_b[k] <= y)) n++;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and run until out_valid (bounded).
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          output int zc, output int lat, output int ones, output int nstream);
        bus.x_code   = x;
        bus.y_code   = y;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1; ones = 0; nstream = 0;
        while (!bus.out_valid && lat < 400) begin
            if (bus.stream_valid) begin
                nstream++;
                ones += int'(bus.z_bit);
            end
            if (lat == 50) chk("zcount_mid_run", int'(bus.z_count), 0);
            // Operand churn and stray requests while running must be ignored.
            bus.x_code   = 8'($urandom);
            bus.y_code   = 8'($urandom);
            bus.in_valid = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        bus.in_valid = 1'b0;
        zc = int'(bus.z_count);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("release_in_ready", int'(bus.in_ready), 1);
        chk("release_out_valid", int'(bus.out_valid), 0);
    endtask

    initial begin
        int zc, lat, ones, nstream, seen, held_z;
        logic [7:0] bx [5];
        logic [7:0] by [5];
        int         bexp [5];
        int idx, nres, last_cyc, cyc;
        logic acc;

        seq_a[0] = 8'h01;
        seq_b[0] = 8'hA5;
        for (int k = 1; k < 255; k++) begin
            seq_a[k] = lfsr_next(seq_a[k-1]);
            seq_b[k] = lfsr_next(seq_b[k-1]);
        end

        tbl[0] = '{8'd0,   8'd0,   255};
        tbl[1] = '{8'd255, 8'd0,   0};
        tbl[2] = '{8'd0,   8'd255, 0};
        tbl[3] = '{8'd255, 8'd255, 255};
        tbl[4] = '{8'd255, 8'd128, 128};
        tbl[5] = '{8'd255, 8'd1,   1};
        for (int i = 6; i < 14; i++) begin
            tbl[i].x     = 8'($urandom);
            tbl[i].y     = 8'($urandom);
            tbl[i].exp_z = model(tbl[i].x, tbl[i].y);
        end

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_code    = 8'd0;
        bus.y_code    = 8'd0;
        step();
        step();
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_stream_valid", int'(bus.stream_valid), 0);
        chk("rst_z_bit", int'(bus.z_bit), 0);
        chk("rst_z_count", int'(bus.z_count), 0);
        rst = 1'b0;
        step();

        // Table-driven vectors (fixed scenarios + random pairs)
        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].x, tbl[i].y, zc, lat, ones, nstream);
            chk($sformatf("vec%0d_z_count", i), zc, tbl[i].exp_z);
            chk($sformatf("vec%0d_latency", i), lat, 256);
            chk($sformatf("vec%0d_stream_len", i), nstream, 255);
            chk($sformatf("vec%0d_stream_ones", i), ones, tbl[i].exp_z);
            release_result();
        end

        // Held result with out_ready low, then handoff edge with in_valid high
        run_op(8'd255, 8'd128, zc, lat, ones, nstream);
        held_z = zc;
        chk("hold_initial_z", held_z, 128);
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.x_code   = 8'($urandom);
            bus.y_code   = 8'($urandom);
            step();
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_z_count", int'(bus.z_count), held_z);
            chk("hold_in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b1;
        bus.x_code    = 8'd0;
        bus.y_code    = 8'd0;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("handoff_in_ready", int'(bus.in_ready), 1);
        chk("handoff_busy", int'(bus.busy), 0);
        chk("handoff_out_valid", int'(bus.out_valid), 0);
        chk("handoff_z_kept", int'(bus.z_count), 128);

        // Reset in the middle of a run, with competing in_valid/out_ready
        bus.x_code = 8'd255; bus.y_code = 8'd128; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (99) step();
        chk("midrun_stream_valid", int'(bus.stream_valid), 1);
        rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_in_ready", int'(bus.in_ready), 1);
        chk("abort_z_count", int'(bus.z_count), 0);
        chk("abort_stream_valid", int'(bus.stream_valid), 0);
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            if (bus.out_valid) seen++;
            step();
        end
        chk("abort_no_out_valid", seen, 0);
        run_op(8'd0, 8'd0, zc, lat, ones, nstream);
        chk("post_abort_z_count", zc, 255);
        chk("post_abort_latency", lat, 256);

        // Reset while a result waits in DONE
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("done_rst_out_valid", int'(bus.out_valid), 0);
        chk("done_rst_z_count", int'(bus.z_count), 0);
        chk("done_rst_in_ready", int'(bus.in_ready), 1);
        step();

        // Back-to-back with in_valid and out_ready held high
        bx[0] = 8'd0;   by[0] = 8'd0;   bexp[0] = 255;
        bx[1] = 8'd255; by[1] = 8'd0;   bexp[1] = 0;
        bx[2] = 8'd255; by[2] = 8'd128; bexp[2] = 128;
        bx[3] = 8'd255; by[3] = 8'd255; bexp[3] = 255;
        bx[4] = 8'd255; by[4] = 8'd1;   bexp[4] = 1;
        idx = 0; nres = 0; last_cyc = 0; cyc = 0;
        bus.out_ready = 1'b1;
        while (nres < 5 && cyc < 5 * 260 + 20) begin
            if (idx < 5) begin
                bus.in_valid = 1'b1;
                bus.x_code   = bx[idx];
                bus.y_code   = by[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            acc = bus.in_ready & bus.in_valid;
            step();
            cyc++;
            if (acc) idx++;
            if (bus.out_valid) begin
                chk($sformatf("b2b%0d_z_count", nres), int'(bus.z_count), bexp[nres]);
                if (nres > 0) chk($sformatf("b2b%0d_gap", nres), cyc - last_cyc, 257);
                last_cyc = cyc;
                nres++;
            end
        end
        chk("b2b_results", nres, 5);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
